// File: rtl/systolic_pe.sv
// One processing element of the weight-stationary grid: a loadable weight, an
// activation pass-through register and a signed multiply-accumulate psum register.
module systolic_pe #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear_acc,
    input  logic                  weight_load,
    input  logic [DATA_WIDTH-1:0] weight_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [ACC_WIDTH-1:0]  psum_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [ACC_WIDTH-1:0]  psum_out
);

    logic [DATA_WIDTH-1:0]          weight;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic [ACC_WIDTH-1:0]           product_ext;

    // Signed cast keeps the product's sign through the widening to the accumulator width.
    assign product     = $signed(a_in) * $signed(weight);
    assign product_ext = ACC_WIDTH'(product);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight <= '0;
        end else if (weight_load) begin
            weight <= weight_in;
        end
    end

    // clear_acc flushes the pipeline but deliberately leaves the stored weight alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out    <= '0;
            psum_out <= '0;
        end else if (clear_acc) begin
            a_out    <= '0;
            psum_out <= '0;
        end else if (enable) begin
            a_out    <= a_in;
            psum_out <= psum_in + product_ext;
        end
    end

endmodule

// File: rtl/systolic_array.sv
// N x N weight-stationary systolic array: activations flow right, partial sums
// flow down, and each column's bottom psum is summed into a per-column accumulator.
module systolic_array #(
    parameter int ARRAY_SIZE = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic                             load_weights,
    input  logic                             clear_acc,
    input  logic                             acc_enable,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] input_activations_flat,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] weight_inputs_flat,
    output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  results_flat
);

    localparam int PTR_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    logic [PTR_W-1:0]      row_ptr;
    logic [DATA_WIDTH-1:0] a_bus        [ARRAY_SIZE][ARRAY_SIZE];
    logic [DATA_WIDTH-1:0] a_edge_unused[ARRAY_SIZE];
    logic [ACC_WIDTH-1:0]  psum_bus     [ARRAY_SIZE+1][ARRAY_SIZE];
    logic [ACC_WIDTH-1:0]  acc          [ARRAY_SIZE];

    // Row pointer restarts at row 0 whenever a load burst is interrupted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_ptr <= '0;
        end else if (load_weights) begin
            row_ptr <= (row_ptr == PTR_W'(ARRAY_SIZE - 1)) ? '0 : row_ptr + PTR_W'(1);
        end else begin
            row_ptr <= '0;
        end
    end

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_row
        assign a_bus[i][0] = input_activations_flat[i*DATA_WIDTH +: DATA_WIDTH];
        for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
            logic [DATA_WIDTH-1:0] a_next;

            if (i == 0) begin : g_top
                assign psum_bus[0][j] = '0;
            end

            if (j == ARRAY_SIZE - 1) begin : g_last
                assign a_edge_unused[i] = a_next;
            end else begin : g_mid
                assign a_bus[i][j+1] = a_next;
            end

            systolic_pe #(
                .DATA_WIDTH(DATA_WIDTH),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_pe (
                .clk        (clk),
                .rst_n      (rst_n),
                .enable     (enable),
                .clear_acc  (clear_acc),
                .weight_load(load_weights && (row_ptr == PTR_W'(i))),
                .weight_in  (weight_inputs_flat[j*DATA_WIDTH +: DATA_WIDTH]),
                .a_in       (a_bus[i][j]),
                .psum_in    (psum_bus[i][j]),
                .a_out      (a_next),
                .psum_out   (psum_bus[i+1][j])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < ARRAY_SIZE; j++) acc[j] <= '0;
        end else if (clear_acc) begin
            for (int j = 0; j < ARRAY_SIZE; j++) acc[j] <= '0;
        end else if (enable && acc_enable) begin
            for (int j = 0; j < ARRAY_SIZE; j++) acc[j] <= acc[j] + psum_bus[ARRAY_SIZE][j];
        end
    end

    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_out
        assign results_flat[j*ACC_WIDTH +: ACC_WIDTH] = acc[j];
    end

endmodule

// File: tb/tb_systolic_array.sv
// Directed and randomized bench for systolic_array; expected sums come from
// plain dot products placed at the documented column latency.
module tb_systolic_array;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          load_weights = 1'b0;
    logic          clear_acc = 1'b0;
    logic          acc_enable = 1'b0;
    logic [N*DW-1:0] input_activations_flat = '0;
    logic [N*DW-1:0] weight_inputs_flat = '0;
    logic [N*AW-1:0] results_flat;

    int total = 0;
    int bad = 0;

    logic signed [DW-1:0] wm [N][N];
    logic signed [DW-1:0] vx [16][N];
    int                   nvec;
    logic [AW-1:0]        model_acc [N];

    systolic_array #(
        .ARRAY_SIZE(N),
        .DATA_WIDTH(DW),
        .ACC_WIDTH (AW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .enable                (enable),
        .load_weights          (load_weights),
        .clear_acc             (clear_acc),
        .acc_enable            (acc_enable),
        .input_activations_flat(input_activations_flat),
        .weight_inputs_flat    (weight_inputs_flat),
        .results_flat          (results_flat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int lane, input logic [AW-1:0] expected);
        logic [AW-1:0] observed;
        observed = results_flat[lane*AW +: AW];
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s lane=%0d observed=%h expected=%h", tag, lane, observed, expected);
        end
    endtask

    task automatic checkBoth(input string tag, input logic [AW-1:0] e0, input logic [AW-1:0] e1);
        checkOutput(tag, 0, e0);
        checkOutput(tag, 1, e1);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic applyStimulus(input bit en, input bit ld, input bit clr, input bit acc_en,
                                 input logic [N*DW-1:0] act, input logic [N*DW-1:0] w);
        enable                 = en;
        load_weights           = ld;
        clear_acc              = clr;
        acc_enable             = acc_en;
        input_activations_flat = act;
        weight_inputs_flat     = w;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*DW-1:0] pack2(input logic [DW-1:0] l0, input logic [DW-1:0] l1);
        return {l1, l0};
    endfunction

    function automatic logic [AW-1:0] dotProduct(input int k, input int col);
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(vx[k][i]) * longint'(wm[i][col]);
        return AW'(s);
    endfunction

    task automatic loadWeights();
        logic [N*DW-1:0] w;
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) w[j*DW +: DW] = wm[r][j];
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, w);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic clearAll();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, '0, '0);
        for (int j = 0; j < N; j++) model_acc[j] = '0;
        checkBoth("clear", '0, '0);
    endtask

    // Vector k enters lane i at cycle k+i; its column-j sum lands at the edge ending k+j+N.
    task automatic streamVectors(input string tag, input bit acc_en);
        logic [N*DW-1:0] act;
        int k;
        for (int c = 0; c < nvec + 2*N; c++) begin
            for (int i = 0; i < N; i++) begin
                k = c - i;
                act[i*DW +: DW] = (k >= 0 && k < nvec) ? vx[k][i] : '0;
            end
            applyStimulus(1'b1, 1'b0, 1'b0, acc_en, act, '0);
            for (int j = 0; j < N; j++) begin
                k = c - j - N;
                if (acc_en && k >= 0 && k < nvec) model_acc[j] = model_acc[j] + dotProduct(k, j);
                checkOutput(tag, j, model_acc[j]);
            end
        end
    endtask

    task automatic setWeights2(input int w00, input int w01, input int w10, input int w11);
        wm[0][0] = DW'(w00); wm[0][1] = DW'(w01);
        wm[1][0] = DW'(w10); wm[1][1] = DW'(w11);
    endtask

    initial begin
        for (int j = 0; j < N; j++) model_acc[j] = '0;

        #1;
        checkBoth("reset_async", '0, '0);
        repeat (2) @(posedge clk);
        #1;
        checkBoth("reset_held", '0, '0);
        rst_n = 1'b1;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
        checkBoth("idle", '0, '0);

        setWeights2(1, 2, 3, 4);
        loadWeights();
        nvec = 1; vx[0][0] = 16'sd5; vx[0][1] = 16'sd7;
        streamVectors("vec57", 1'b1);
        checkBoth("vec57_final", 32'd26, 32'd38);

        clearAll();
        vx[0][0] = 16'sd6; vx[0][1] = 16'sd8;
        streamVectors("vec68", 1'b1);
        checkBoth("vec68_final", 32'd30, 32'd44);

        clearAll();
        nvec = 2;
        vx[0][0] = 16'sd5; vx[0][1] = 16'sd7;
        vx[1][0] = 16'sd6; vx[1][1] = 16'sd8;
        streamVectors("b2b", 1'b1);
        checkBoth("b2b_final", 32'd56, 32'd82);

        clearAll();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, pack2(16'd5, 16'd0), '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, pack2(16'd0, 16'd7), '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
        checkBoth("partial", 32'd26, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, '0, '0);
        checkBoth("clear_mid", 32'd0, 32'd0);
        for (int j = 0; j < N; j++) model_acc[j] = '0;
        nvec = 1; vx[0][0] = 16'sd5; vx[0][1] = 16'sd7;
        streamVectors("rerun", 1'b1);
        checkBoth("rerun_final", 32'd26, 32'd38);

        clearAll();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, pack2(16'd5, 16'd0), '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, pack2(16'd0, 16'd7), '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
        checkBoth("pre_freeze", 32'd26, 32'd0);
        for (int f = 0; f < 3; f++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, N*DW'($urandom), '0);
            checkBoth("frozen", 32'd26, 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
        checkBoth("resume", 32'd26, 32'd38);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
        checkBoth("resume_flush", 32'd26, 32'd38);

        clearAll();
        setWeights2(-1, 0, 0, 0);
        loadWeights();
        nvec = 1; vx[0][0] = 16'sd3; vx[0][1] = 16'sd0;
        streamVectors("signed", 1'b1);
        checkBoth("signed_final", 32'hFFFF_FFFD, 32'd0);

        clearAll();
        setWeights2(1, 2, 3, 4);
        loadWeights();
        vx[0][0] = 16'sd5; vx[0][1] = 16'sd7;
        streamVectors("acc_off", 1'b0);
        checkBoth("acc_off_final", 32'd0, 32'd0);

        clearAll();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) wm[i][j] = DW'($urandom);
        loadWeights();
        nvec = 6;
        for (int k = 0; k < nvec; k++)
            for (int i = 0; i < N; i++) vx[k][i] = DW'($urandom);
        streamVectors("random", 1'b1);

        nvec = 2;
        for (int k = 0; k < nvec; k++)
            for (int i = 0; i < N; i++) vx[k][i] = DW'($urandom_range(1, 1000));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, pack2(vx[0][0], 16'd0), '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, pack2(vx[1][0], vx[0][1]), '0);
        #3;
        rst_n = 1'b0;
        #1;
        checkBoth("reset_mid", '0, '0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) wm[i][j] = '0;
        for (int j = 0; j < N; j++) model_acc[j] = '0;
        nvec = 1; vx[0][0] = 16'sd5; vx[0][1] = 16'sd7;
        streamVectors("post_reset", 1'b1);
        setWeights2(1, 2, 3, 4);
        loadWeights();
        streamVectors("reload", 1'b1);
        checkBoth("reload_final", 32'd26, 32'd38);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_array.md
SYSTOLIC_ARRAY -- requirements
Module: systolic_array

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 2, the number of PE rows and columns (N).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the activation and weight width.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, the partial-sum, accumulator and result width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: advances the activation and partial-sum pipeline.
REQ-007 SHALL have port load_weights, input, 1 bit: writes one weight row per cycle.
REQ-008 SHALL have port clear_acc, input, 1 bit: synchronous clear of the accumulators and pipeline.
REQ-009 SHALL have port acc_enable, input, 1 bit: permits accumulator update.
REQ-010 SHALL have port input_activations_flat, input, N*DATA_WIDTH bits: lane i = bits [i*DATA_WIDTH +: DATA_WIDTH], feeds row i.
REQ-011 SHALL have port weight_inputs_flat, input, N*DATA_WIDTH bits: lane j = weight for column j.
REQ-012 SHALL have port results_flat, output, N*ACC_WIDTH bits: lane j = accumulator of column j.

Function
REQ-013 SHALL be a weight-stationary N x N PE grid; PE(i,j) holds weight W[i][j].
REQ-014 SHALL keep a row pointer, 0 after reset: each cycle with load_weights=1 writes lane j into W[ptr][j] and increments ptr modulo N; ptr returns to 0 on any cycle with load_weights=0.
REQ-015 SHALL leave weight loading independent of enable, clear_acc and acc_enable; a newly written weight is used from the next cycle onward.
REQ-016 SHALL, on each edge with enable=1 and clear_acc=0, have every PE(i,j) register a_out <= a_in and psum_out <= psum_in + a_in*W[i][j].
REQ-017 SHALL take a_in of PE(i,0) from activation lane i and a_in of PE(i,j>0) from a_out of PE(i,j-1); psum_in of row 0 SHALL be 0 and of row i>0 psum_out of PE(i-1,j).
REQ-018 SHALL perform no internal input skew: the caller delays lane i by i cycles for vector alignment.
REQ-019 SHALL, on each edge with enable=1, acc_enable=1 and clear_acc=0, do acc[j] <= acc[j] + psum_out of PE(N-1,j).
REQ-020 SHALL hold all PE pipeline registers and accumulators when enable=0; weights still load.
REQ-021 SHALL treat operands as signed two's complement: the 2*DATA_WIDTH product sign-extends to ACC_WIDTH, and sums wrap modulo 2^ACC_WIDTH without saturation.
REQ-022 SHALL give clear_acc priority over enable/acc_enable: it zeroes all accumulators, a_out and psum_out registers, but not the weights.
REQ-023 SHALL drive results_flat directly from the accumulator registers, with no output logic.
REQ-024 SHALL, when lane 0 of a skewed vector is driven in cycle t, add that vector's column-j dot product into acc[j] at the edge ending cycle t+j+N.

Reset
REQ-025 SHALL clear all weights, activation registers, psum registers, accumulators and the row pointer on rst_n=0, immediately and regardless of clk, so results_flat=0.
REQ-026 SHALL resume normal operation on the first rising edge after rst_n returns high; a reset mid-computation discards all partial results.

Structure
REQ-027 SHALL need no shared package; ARRAY_SIZE/DATA_WIDTH/ACC_WIDTH are the only constants and pass as parameters.
REQ-028 SHALL use one sub-module, systolic_pe, holding one weight register, activation pass-through register and psum register, instantiated N x N by generate loops.

Verification
REQ-029 SHALL check: reset, then idle -> results_flat = 0; assert rst_n low mid-run -> outputs 0 immediately.
REQ-030 SHALL check: load rows (1,2) then (3,4); skewed vector (5,7) (cycle0 lanes (5,0), cycle1 (0,7)); flush zeros -> C[0]=26, C[1]=38.
REQ-031 SHALL check: same weights, clear_acc, vector (6,8) skewed -> C[0]=30, C[1]=44; vectors (5,7) and (6,8) back-to-back -> C[0]=56, C[1]=82.
REQ-032 SHALL check: clear_acc mid-stream -> results 0 next cycle, weights retained (rerun (5,7) gives 26/38).
REQ-033 SHALL check: enable=0 for 3 cycles mid-stream -> results frozen, final sums unchanged after resume.
REQ-034 SHALL check: signed/wrap, W[0][0]=-1, vector (3,0) -> C[0]=0xFFFFFFFD; acc_enable=0 throughout -> results stay 0.
